// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: forward-select codes, FSM states and default register index width
package hazard_ctrl_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam int DEF_REG_AW = 3;
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
  function automatic logic [1:0] fwd_sel(input logic x_hit, input logic m_hit);
    return x_hit ? FWD_MEM : m_hit ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: X/M/W shadow of destination info plus per-slot source match vectors
//  clk, rst_n           clock, async active-low reset
//  adv_i                shift the shadow pipeline this edge
//  bubble_i             X loads an empty slot instead of the ID info
//  valid_i/wr_i/load_i  ID instruction flags; dst_i its destination index
//  rs_i/rt_i, use_*_i   ID source indices and whether they are read
//  hit_rs_o/hit_rt_o    per-slot match, bit 0 = X, 1 = M, 2 = W
//  x_load_o             X slot holds a load
module hazard_scoreboard #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic              wr_i,
  input  logic              load_i,
  input  logic [REG_AW-1:0] dst_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  output logic [2:0]        hit_rs_o,
  output logic [2:0]        hit_rt_o,
  output logic              x_load_o
);
  logic [2:0] v_q, wr_q, ld_q;
  logic [REG_AW-1:0] dst_q [3];
  logic keep;
  assign keep = valid_i & ~bubble_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      wr_q <= '0;
      ld_q <= '0;
      for (int i = 0; i < 3; i++) dst_q[i] <= '0;
    end else if (adv_i) begin
      v_q <= {v_q[1:0], keep};
      // $0 is never a forwarding source, so a write to it is recorded as no write
      wr_q <= {wr_q[1:0], keep & wr_i & (|dst_i)};
      ld_q <= {ld_q[1:0], keep & load_i};
      dst_q[0] <= keep ? dst_i : '0;
      dst_q[1] <= dst_q[0];
      dst_q[2] <= dst_q[1];
    end
  for (genvar i = 0; i < 3; i++) begin : g_hit
    assign hit_rs_o[i] = v_q[i] & wr_q[i] & use_rs_i & (rs_i == dst_q[i]);
    assign hit_rt_o[i] = v_q[i] & wr_q[i] & use_rt_i & (rt_i == dst_q[i]);
  end
  assign x_load_o = ld_q[0];
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush sequencing and registered EX forwarding selects
//  freeze                 global hold; all state holds, stall/flush outputs low
//  *_d                    ID-stage instruction info
//  branch_taken_x         taken branch resolved in EX
//  stall_fd/flush_fd      hold / squash IF/ID
//  flush_x                bubble into ID/EX
//  fwd_a_x/fwd_b_x        EX operand selects (00 RF, 01 MEM, 10 WB)
//  load_use_cnt/flush_cnt saturating event counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = DEF_REG_AW,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              uses_rs_d,
  input  logic              uses_rt_d,
  input  logic              reg_dst_d,
  input  logic              reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic              branch_taken_x,
  output logic              stall_fd,
  output logic              flush_fd,
  output logic              flush_x,
  output logic [1:0]        fwd_a_x,
  output logic [1:0]        fwd_b_x,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam int FW = FLUSH_CYCLES > 2 ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] CNT_INIT = FW'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
  state_t state_q, state_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;
  logic [2:0] hit_rs, hit_rt;
  logic x_load, br, lu, act;
  logic unused_w;
  hazard_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv_i    (~freeze),
    .bubble_i (flush_x),
    .valid_i  (valid_d),
    .wr_i     (reg_write_d),
    .load_i   (mem_to_reg_d),
    .dst_i    (reg_dst_d ? rd_d : rt_d),
    .rs_i     (rs_d),
    .rt_i     (rt_d),
    .use_rs_i (uses_rs_d),
    .use_rt_i (uses_rt_d),
    .hit_rs_o (hit_rs),
    .hit_rt_o (hit_rt),
    .x_load_o (x_load)
  );
  // WB-stage reads are covered by the write-through register file
  assign unused_w = hit_rs[2] ^ hit_rt[2];
  always_comb begin
    act = rst_n & ~freeze;
    br = (state_q == ST_FLUSH) | branch_taken_x;
    lu = x_load & (hit_rs[0] | hit_rt[0]);
    flush_fd = act & br;
    flush_x = act & (br | lu);
    // a squashed ID instruction cannot cause a stall
    stall_fd = act & ~br & lu;
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == ST_RUN) begin
      if (branch_taken_x && FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d = CNT_INIT;
      end
    end else if (cnt_q == '0) state_d = ST_RUN;
    else cnt_d = cnt_q - 1'b1;
    // a load in X never forwards from EX; the stall moves it to M first
    fwd_a_d = flush_x ? FWD_RF : fwd_sel(hit_rs[0] & ~x_load, hit_rs[1]);
    fwd_b_d = flush_x ? FWD_RF : fwd_sel(hit_rt[0] & ~x_load, hit_rt[1]);
    lu_cnt_d = (stall_fd && !(&lu_cnt_q)) ? lu_cnt_q + 1'b1 : lu_cnt_q;
    fl_cnt_d = (flush_fd && !(&fl_cnt_q)) ? fl_cnt_q + 1'b1 : fl_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else if (!freeze) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  assign fwd_a_x = fwd_a_q;
  assign fwd_b_x = fwd_b_q;
  assign load_use_cnt = lu_cnt_q;
  assign flush_cnt = fl_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stalls, flushes, forwarding, freeze and reset
module tb_hazard_ctrl;
  logic clk = 0, rst_n = 0, freeze = 0, valid_d = 0;
  logic [2:0] rs_d = 0, rt_d = 0, rd_d = 0;
  logic uses_rs_d = 0, uses_rt_d = 0, reg_dst_d = 0, reg_write_d = 0, mem_to_reg_d = 0;
  logic branch_taken_x = 0;
  logic stall_fd, flush_fd, flush_x;
  logic [1:0] fwd_a_x, fwd_b_x;
  logic [15:0] load_use_cnt, flush_cnt;
  int n_chk = 0, n_fail = 0;
  hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .valid_d(valid_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .reg_dst_d(reg_dst_d), .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
    .branch_taken_x(branch_taken_x), .stall_fd(stall_fd), .flush_fd(flush_fd),
    .flush_x(flush_x), .fwd_a_x(fwd_a_x), .fwd_b_x(fwd_b_x),
    .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic urs, input logic urt,
                        input logic rdst, input logic rw, input logic ld);
    valid_d = v; rs_d = rs; rt_d = rt; rd_d = rd; uses_rs_d = urs; uses_rt_d = urt;
    reg_dst_d = rdst; reg_write_d = rw; mem_to_reg_d = ld;
  endtask
  initial begin
    branch_taken_x = 1;
    #3;
    chk("rst_stall", stall_fd, 0);
    chk("rst_flush_fd", flush_fd, 0);
    chk("rst_flush_x", flush_x, 0);
    chk("rst_fwd_a", fwd_a_x, 0);
    chk("rst_fwd_b", fwd_b_x, 0);
    chk("rst_lu_cnt", load_use_cnt, 0);
    chk("rst_fl_cnt", flush_cnt, 0);
    tick;
    chk("rst_edge_flush_fd", flush_fd, 0);
    branch_taken_x = 0;
    rst_n = 1;
    set_id(1, 1, 2, 0, 1, 0, 0, 1, 1);
    #1 chk("lw_no_stall", stall_fd, 0);
    tick;
    set_id(1, 2, 1, 3, 1, 1, 1, 1, 0);
    #1 chk("lu_stall", stall_fd, 1);
    chk("lu_flush_x", flush_x, 1);
    chk("lu_flush_fd", flush_fd, 0);
    tick;
    chk("lu_cnt1", load_use_cnt, 1);
    chk("lu_bubble_fwd_a", fwd_a_x, 0);
    #1 chk("lu_once_stall", stall_fd, 0);
    chk("lu_once_flush_x", flush_x, 0);
    tick;
    chk("lu_dep_fwd_a", fwd_a_x, 2'b10);
    chk("lu_dep_fwd_b", fwd_b_x, 2'b00);
    chk("lu_cnt_hold", load_use_cnt, 1);
    set_id(1, 1, 1, 2, 1, 1, 1, 1, 0);
    #1 chk("alu_no_stall", stall_fd, 0);
    tick;
    set_id(1, 1, 2, 4, 1, 1, 1, 1, 0);
    tick;
    chk("ex_fwd_b", fwd_b_x, 2'b01);
    chk("ex_fwd_a", fwd_a_x, 2'b00);
    set_id(1, 1, 2, 5, 1, 1, 1, 1, 0);
    tick;
    chk("mem_fwd_b", fwd_b_x, 2'b10);
    chk("mem_fwd_a", fwd_a_x, 2'b00);
    set_id(1, 1, 1, 2, 1, 1, 1, 1, 0);
    tick;
    set_id(1, 2, 2, 0, 1, 0, 0, 1, 0);
    tick;
    chk("addi_fwd_a", fwd_a_x, 2'b01);
    chk("addi_fwd_b_unused", fwd_b_x, 2'b00);
    set_id(1, 2, 2, 6, 1, 1, 1, 1, 0);
    tick;
    chk("nearest_fwd_a", fwd_a_x, 2'b01);
    chk("nearest_fwd_b", fwd_b_x, 2'b01);
    set_id(1, 2, 2, 0, 1, 1, 1, 1, 0);
    tick;
    chk("wb_fwd_a", fwd_a_x, 2'b10);
    chk("wb_fwd_b", fwd_b_x, 2'b10);
    set_id(1, 0, 0, 7, 1, 1, 1, 1, 0);
    tick;
    chk("r0_fwd_a", fwd_a_x, 2'b00);
    chk("r0_fwd_b", fwd_b_x, 2'b00);
    set_id(1, 1, 3, 0, 1, 0, 0, 1, 1);
    tick;
    set_id(1, 3, 0, 4, 1, 0, 1, 1, 0);
    branch_taken_x = 1;
    #1 chk("br_lu_stall", stall_fd, 0);
    chk("br_flush_fd", flush_fd, 1);
    chk("br_flush_x", flush_x, 1);
    tick;
    branch_taken_x = 0;
    chk("br_fl_cnt1", flush_cnt, 1);
    #1 chk("fl2_flush_fd", flush_fd, 1);
    chk("fl2_flush_x", flush_x, 1);
    chk("fl2_stall", stall_fd, 0);
    tick;
    #1 chk("fl3_flush_fd", flush_fd, 1);
    chk("fl3_flush_x", flush_x, 1);
    tick;
    chk("fl_cnt3", flush_cnt, 3);
    chk("fl_lu_cnt", load_use_cnt, 1);
    set_id(1, 1, 1, 6, 1, 1, 1, 1, 0);
    #1 chk("run_flush_fd", flush_fd, 0);
    chk("run_flush_x", flush_x, 0);
    chk("run_stall", stall_fd, 0);
    tick;
    set_id(1, 6, 4, 0, 1, 0, 0, 1, 1);
    tick;
    chk("pre_frz_fwd_a", fwd_a_x, 2'b01);
    set_id(1, 4, 0, 5, 1, 0, 1, 1, 0);
    freeze = 1;
    #1 chk("frz_stall", stall_fd, 0);
    chk("frz_flush_x", flush_x, 0);
    chk("frz_flush_fd", flush_fd, 0);
    repeat (4) tick;
    chk("frz_fwd_a", fwd_a_x, 2'b01);
    chk("frz_lu_cnt", load_use_cnt, 1);
    chk("frz_fl_cnt", flush_cnt, 3);
    chk("frz_stall_end", stall_fd, 0);
    freeze = 0;
    #1 chk("unfrz_stall", stall_fd, 1);
    chk("unfrz_flush_x", flush_x, 1);
    tick;
    chk("unfrz_lu_cnt", load_use_cnt, 2);
    chk("unfrz_fwd_a", fwd_a_x, 2'b00);
    #1 chk("unfrz_once", stall_fd, 0);
    tick;
    chk("unfrz_dep_fwd_a", fwd_a_x, 2'b10);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    branch_taken_x = 1;
    tick;
    branch_taken_x = 0;
    #1 chk("mid_flush_fd", flush_fd, 1);
    rst_n = 0;
    #1 chk("async_flush_fd", flush_fd, 0);
    chk("async_flush_x", flush_x, 0);
    chk("async_fl_cnt", flush_cnt, 0);
    chk("async_lu_cnt", load_use_cnt, 0);
    chk("async_fwd_a", fwd_a_x, 0);
    tick;
    rst_n = 1;
    #1 chk("rel_flush_fd", flush_fd, 0);
    chk("rel_flush_x", flush_x, 0);
    tick;
    chk("rel_edge_flush_fd", flush_fd, 0);
    chk("rel_fl_cnt", flush_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
